// File: rtl/updi_pkg.sv
// updi_pkg: shared UPDI constants and responder state type
package updi_pkg;
  localparam logic [7:0] SYNC_BYTE = 8'h55;
  localparam logic [3:0] OP_LDCS = 4'h8;
  localparam logic [3:0] OP_STCS = 4'hC;
  typedef enum logic [2:0] {IDLE, INSTR, STCS_DATA, GUARD, RESP_TX} resp_state_e;
endpackage

// File: rtl/uart.sv
// uart: one-bit-per-clock UART with configurable data bits, parity and stop bits
module uart #(
  parameter int DATA_BITS = 8,
  parameter string PARITY_BIT = "even",
  parameter int STOP_BITS = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic rx,
  output logic rx_valid,
  output logic rx_err,
  output logic [DATA_BITS-1:0] rx_data,
  input  logic tx_start,
  input  logic [DATA_BITS-1:0] tx_data,
  output logic tx,
  output logic tx_ready
);
  localparam int PB = (PARITY_BIT == "none") ? 0 : 1;
  localparam int N = DATA_BITS + PB + STOP_BITS;
  localparam int FL = N + 1;
  localparam int CW = $clog2(FL + 1);
  logic [CW-1:0] rcnt_q, rcnt_d, tcnt_q, tcnt_d;
  logic [N-2:0] rsh_q, rsh_d;
  logic [N-1:0] rf;
  logic [FL-1:0] tf;
  logic [FL-2:0] tsh_q, tsh_d;
  logic tx_q, tx_d, go;
  // receiver: rx_valid/rx_err are presented during the last stop bit itself
  always_comb begin
    rf = {rx, rsh_q};
    rx_valid = rcnt_q == CW'(N);
    rx_data = rf[DATA_BITS-1:0];
    rx_err = ~&rf[N-1:DATA_BITS+PB] | ((PB != 0) && ((^rf[DATA_BITS:0]) != (PARITY_BIT == "odd")));
    rsh_d = (rcnt_q != '0 && !rx_valid) ? {rx, rsh_q[N-2:1]} : rsh_q;
    rcnt_d = rx_valid ? '0 : rcnt_q != '0 ? rcnt_q + 1'b1 : {{(CW-1){1'b0}}, ~rx};
  end
  // transmitter: ready is reported during the final stop bit
  always_comb begin
    tf = '1;
    tf[DATA_BITS:0] = {tx_data, 1'b0};
    if (PB != 0) tf[DATA_BITS+1] = (^tx_data) ^ (PARITY_BIT == "odd");
    tx_ready = tcnt_q == '0;
    go = tx_start && tx_ready;
    tx_d = go ? 1'b0 : tx_ready ? 1'b1 : tsh_q[0];
    tsh_d = go ? tf[FL-1:1] : {1'b1, tsh_q[FL-2:1]};
    tcnt_d = go ? CW'(N) : tx_ready ? '0 : tcnt_q - 1'b1;
  end
  // state registers; reset parks the line high
  always_ff @(posedge clk) begin
    if (rst) begin
      rcnt_q <= '0;
      rsh_q <= '0;
      tcnt_q <= '0;
      tsh_q <= '1;
      tx_q <= 1'b1;
    end else begin
      rcnt_q <= rcnt_d;
      rsh_q <= rsh_d;
      tcnt_q <= tcnt_d;
      tsh_q <= tsh_d;
      tx_q <= tx_d;
    end
  end
  assign tx = tx_q;
endmodule

// File: rtl/updi_responder.sv
// updi_responder: UPDI LDCS/STCS responder; define UPDI_RESPONDER_ERR_REG_EN to map err onto CS register 0x2
module updi_responder
  import updi_pkg::*;
#(
  parameter int GUARD_CYCLES = 2,
  parameter logic [7:0] REVISION = 8'h30
) (
  input  logic clk,
  input  logic rst,
  input  logic rx,
  output logic tx,
  output logic cs_we,
  output logic [3:0] cs_waddr,
  output logic [7:0] cs_wdata,
  output logic busy,
  output logic err
);
  localparam int GW = $clog2(GUARD_CYCLES + 1);
  resp_state_e state_q, state_d;
  logic [3:0] addr_q, addr_d, cs_waddr_q, cs_waddr_d;
  logic [15:0][7:0] regs_q, regs_d;
  logic [GW-1:0] gcnt_q, gcnt_d;
  logic [7:0] cs_wdata_q, cs_wdata_d, rd_data, rx_data;
  logic err_q, err_d, cs_we_q, cs_we_d;
  logic rx_valid, rx_err, tx_start, tx_ready, listen, line_rx;
  assign listen = state_q inside {IDLE, INSTR, STCS_DATA};
  assign line_rx = rx | ~listen;
  uart #(.DATA_BITS(8), .PARITY_BIT("even"), .STOP_BITS(2)) u_uart (
    .clk(clk),
    .rst(~rst),
    .rx(line_rx),
    .rx_valid(rx_valid),
    .rx_err(rx_err),
    .rx_data(rx_data),
    .tx_start(tx_start),
    .tx_data(rd_data),
    .tx(tx),
    .tx_ready(tx_ready)
  );
  // read mux feeding the LDCS response
  always_comb begin
`ifdef UPDI_RESPONDER_ERR_REG_EN
    rd_data = addr_q == 4'h0 ? REVISION : addr_q == 4'h2 ? {7'b0, err_q} : regs_q[addr_q];
`else
    rd_data = addr_q == 4'h0 ? REVISION : regs_q[addr_q];
`endif
  end
  // protocol FSM and register file update
  always_comb begin
    state_d = state_q;
    addr_d = addr_q;
    regs_d = regs_q;
    err_d = err_q;
    gcnt_d = gcnt_q;
    cs_we_d = 1'b0;
    cs_waddr_d = cs_waddr_q;
    cs_wdata_d = cs_wdata_q;
    tx_start = 1'b0;
    if (listen && rx_valid && rx_err) begin
      err_d = 1'b1;
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: state_d = (rx_valid && rx_data == SYNC_BYTE) ? INSTR : IDLE;
        INSTR: if (rx_valid) begin
          addr_d = rx_data[3:0];
          gcnt_d = GW'(GUARD_CYCLES - 1);
          state_d = rx_data[7:4] == OP_LDCS ? GUARD : rx_data[7:4] == OP_STCS ? STCS_DATA : IDLE;
          err_d = err_q | (rx_data[7:4] != OP_LDCS && rx_data[7:4] != OP_STCS);
        end
        STCS_DATA: if (rx_valid) begin
          cs_we_d = 1'b1;
          cs_waddr_d = addr_q;
          cs_wdata_d = rx_data;
          state_d = IDLE;
`ifdef UPDI_RESPONDER_ERR_REG_EN
          if (addr_q == 4'h2) err_d = err_q & ~rx_data[0];
          else if (addr_q != 4'h0) regs_d[addr_q] = rx_data;
`else
          if (addr_q != 4'h0) regs_d[addr_q] = rx_data;
`endif
        end
        GUARD: begin
          tx_start = gcnt_q == '0;
          gcnt_d = gcnt_q - 1'b1;
          state_d = tx_start ? RESP_TX : GUARD;
        end
        RESP_TX: state_d = tx_ready ? IDLE : RESP_TX;
        default: state_d = IDLE;
      endcase
    end
  end
  // state registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      addr_q <= '0;
      regs_q <= '0;
      err_q <= 1'b0;
      gcnt_q <= '0;
      cs_we_q <= 1'b0;
      cs_waddr_q <= '0;
      cs_wdata_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q <= addr_d;
      regs_q <= regs_d;
      err_q <= err_d;
      gcnt_q <= gcnt_d;
      cs_we_q <= cs_we_d;
      cs_waddr_q <= cs_waddr_d;
      cs_wdata_q <= cs_wdata_d;
    end
  end
  assign busy = state_q != IDLE;
  assign err = err_q;
  assign cs_we = cs_we_q;
  assign cs_waddr = cs_waddr_q;
  assign cs_wdata = cs_wdata_q;
endmodule

// File: tb/tb_updi_responder.sv
// tb_updi_responder: cycle-timeline model of the UPDI responder plus directed literal checks
module tb_updi_responder;
  localparam int G = 2;
  localparam int MAXC = 2000;
`ifdef UPDI_RESPONDER_ERR_REG_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif
  logic clk = 1'b0, rst = 1'b0, rx = 1'b1;
  logic tx, cs_we, busy, err;
  logic [3:0] cs_waddr;
  logic [7:0] cs_wdata;
  int cyc = 0, n_checks = 0, n_err = 0, we_cnt = 0, low_cnt = 0;
  bit checking = 1'b0;
  logic e_tx [MAXC];
  logic e_we [MAXC];
  logic e_busy [MAXC];
  logic e_err [MAXC];
  logic [3:0] e_wa [MAXC];
  logic [7:0] e_wd [MAXC];
  int m_st = 0, m_resp_end = 0;
  logic [3:0] m_addr = '0;
  logic m_err = 1'b0;
  logic [7:0] m_regs [16];

  updi_responder #(.GUARD_CYCLES(G), .REVISION(8'h30)) dut (
    .clk(clk), .rst(rst), .rx(rx), .tx(tx), .cs_we(cs_we),
    .cs_waddr(cs_waddr), .cs_wdata(cs_wdata), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at cycle %0d: got %0h, want %0h", name, cyc, act, exp);
    end
  endtask

  // expected value timelines: from cycle c onward a signal holds v
  task automatic fill(input int which, input int c, input int v);
    for (int i = c; i < MAXC; i++)
      case (which)
        0: e_tx[i] = v[0];
        1: e_busy[i] = v[0];
        2: e_err[i] = v[0];
        3: e_wa[i] = v[3:0];
        4: e_wd[i] = v[7:0];
        default: e_we[i] = v[0];
      endcase
  endtask

  function automatic logic [7:0] m_rd(input logic [3:0] a);
    return a == 4'h0 ? 8'h30 : (ERR_EN && a == 4'h2) ? {7'b0, m_err} : m_regs[a];
  endfunction

  task automatic model_reset(input int r);
    fill(0, r, 1); fill(1, r, 0); fill(2, r, 0); fill(3, r, 0); fill(4, r, 0); fill(5, r, 0);
    m_st = 0; m_err = 1'b0; m_resp_end = 0;
    for (int i = 0; i < 16; i++) m_regs[i] = 8'h00;
  endtask

  // protocol model: a byte whose last stop bit is on cycle s takes effect from s+1
  task automatic model_byte(input int s, input logic [7:0] b, input bit bad);
    int c;
    logic [11:0] fr;
    c = s + 1;
    if (s <= m_resp_end) return;
    if (bad) begin
      m_err = 1'b1; fill(2, c, 1); fill(1, c, 0); m_st = 0;
    end else if (m_st == 0) begin
      if (b == 8'h55) begin m_st = 1; fill(1, c, 1); end
    end else if (m_st == 1) begin
      m_st = 0;
      if (b[7:4] == 4'h8) begin
        fr = {2'b11, ^m_rd(b[3:0]), m_rd(b[3:0]), 1'b0};
        for (int k = 0; k < 12; k++) e_tx[c + G + k] = fr[k];
        fill(1, c + G + 12, 0);
        m_resp_end = c + G + 11;
      end else if (b[7:4] == 4'hC) begin
        m_addr = b[3:0]; m_st = 2;
      end else begin
        m_err = 1'b1; fill(2, c, 1); fill(1, c, 0);
      end
    end else begin
      m_st = 0; e_we[c] = 1'b1; fill(3, c, m_addr); fill(4, c, b); fill(1, c, 0);
      if (ERR_EN && m_addr == 4'h2) begin
        if (b[0]) begin m_err = 1'b0; fill(2, c, 0); end
      end else if (m_addr != 4'h0) m_regs[m_addr] = b;
    end
  endtask

  // kind: 0 clean, 1 corrupted parity, 2 first stop bit low
  task automatic send_byte(input logic [7:0] b, input int kind = 0);
    logic [11:0] f;
    f = {1'b1, (kind == 2) ? 1'b0 : 1'b1, (^b) ^ (kind == 1), b, 1'b0};
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1; rx = f[i];
      if (i == 11) model_byte(cyc, b, kind != 0);
    end
  endtask

  task automatic do_reset();
    @(posedge clk); #1; rst = 1'b0;
    model_reset(cyc + 1);
    @(posedge clk); #1; rst = 1'b1;
  endtask

  task automatic capture(input string name, input logic [11:0] want);
    logic [11:0] f;
    int gap;
    f = '1; gap = 0;
    @(negedge clk);
    while (tx !== 1'b0 && gap < 30) begin @(negedge clk); gap++; end
    chk({name, "_start"}, tx, 0);
    for (int i = 0; i < 12; i++) begin f[i] = tx; @(negedge clk); end
    chk({name, "_guard"}, gap - 1, 2);
    chk({name, "_frame"}, f, want);
    chk({name, "_busy_end"}, busy, 0);
  endtask

  // single compare process against the model timeline
  always @(negedge clk) if (checking && cyc < MAXC) begin
    chk("tx", tx, e_tx[cyc]);
    chk("busy", busy, e_busy[cyc]);
    chk("err", err, e_err[cyc]);
    chk("cs_we", cs_we, e_we[cyc]);
    chk("cs_waddr", cs_waddr, e_wa[cyc]);
    chk("cs_wdata", cs_wdata, e_wd[cyc]);
    if (cs_we === 1'b1) we_cnt++;
    if (tx === 1'b0) low_cnt++;
  end

  initial begin
    #40000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int w0, l0;
    model_reset(0);
    @(posedge clk); #1; checking = 1'b1;
    @(negedge clk);
    chk("rst_tx", tx, 1); chk("rst_busy", busy, 0); chk("rst_err", err, 0);
    chk("rst_we", cs_we, 0); chk("rst_waddr", cs_waddr, 0); chk("rst_wdata", cs_wdata, 0);
    @(posedge clk); #1; rst = 1'b1;
    w0 = we_cnt; l0 = low_cnt;
    send_byte(8'h55); send_byte(8'hC3); send_byte(8'hA7);
    repeat (3) @(negedge clk);
    chk("stcs_pulses", we_cnt - w0, 1);
    chk("stcs_waddr", cs_waddr, 3);
    chk("stcs_wdata", cs_wdata, 8'hA7);
    chk("stcs_busy", busy, 0);
    chk("stcs_no_tx", low_cnt - l0, 0);
    send_byte(8'h55); send_byte(8'h83);
    capture("ldcs3", 12'hF4E);
    send_byte(8'h55); send_byte(8'hCF); send_byte(8'h5A);
    send_byte(8'h55); send_byte(8'h8F);
    capture("ldcsF", 12'hCB4);
    send_byte(8'h55); send_byte(8'hC0); send_byte(8'hFF);
    send_byte(8'h55); send_byte(8'h80);
    capture("ldcs0", 12'hC60);
    send_byte(8'h55); send_byte(8'hC2); send_byte(8'h3C);
    send_byte(8'h55); send_byte(8'h82);
    capture("ldcs2", ERR_EN ? 12'hC00 : 12'hC78);
    send_byte(8'h55); send_byte(8'h12);
    repeat (2) @(negedge clk);
    chk("badop_err", err, 1); chk("badop_idle", busy, 0);
    send_byte(8'h55); send_byte(8'h81);
    capture("ldcs1", 12'hC00);
    do_reset();
    send_byte(8'h55, 1);
    repeat (2) @(negedge clk);
    chk("parity_err", err, 1);
    l0 = low_cnt;
    send_byte(8'h83);
    repeat (25) @(negedge clk);
    chk("nosync_no_tx", low_cnt - l0, 0);
    chk("nosync_busy", busy, 0);
    do_reset();
    w0 = we_cnt;
    send_byte(8'h55); send_byte(8'hC4); send_byte(8'h99, 2);
    repeat (3) @(negedge clk);
    chk("frame_err", err, 1); chk("frame_no_we", we_cnt - w0, 0);
    send_byte(8'h55); send_byte(8'h84);
    capture("ldcs4", 12'hC00);
    send_byte(8'h55); send_byte(8'hC3); send_byte(8'hA7);
    send_byte(8'h55); send_byte(8'h83);
    begin
      int n;
      n = 0;
      while (tx !== 1'b0 && n < 30) begin @(negedge clk); n++; end
    end
    chk("midresp_started", tx, 0);
    repeat (2) @(negedge clk);
    chk("midresp_busy", busy, 1);
    do_reset();
    @(negedge clk);
    chk("midresp_rst_tx", tx, 1); chk("midresp_rst_busy", busy, 0);
    send_byte(8'h55); send_byte(8'h12);
    send_byte(8'h55); send_byte(8'hC2); send_byte(8'h01);
    repeat (2) @(negedge clk);
    chk("errclr", err, ERR_EN ? 0 : 1);
    send_byte(8'h55); send_byte(8'h82);
    capture("ldcs2b", ERR_EN ? 12'hC00 : 12'hE02);
    repeat (4) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule

// File: doc/updi_responder.md
UPDI_RESPONDER -- requirements
Module: updi_responder

Interface
REQ-001 Parameter GUARD_CYCLES, default 2: idle clk cycles between the last received stop bit and the response start bit.
REQ-002 Parameter REVISION, default 8'h30: read-only value of CS register 0x0.
REQ-003 clk  input  1  single clock; one UART bit per clk cycle.
REQ-004 rst  input  1  synchronous, active-low reset.
REQ-005 rx  input  1  serial line from the initiator; idle high.
REQ-006 tx  output  1  serial line to the initiator; idle high.
REQ-007 cs_we  output  1  one-cycle pulse when an STCS commits.
REQ-008 cs_waddr  output  4  register address of the committed STCS.
REQ-009 cs_wdata  output  8  data of the committed STCS.
REQ-010 busy  output  1  high whenever the state is not IDLE.
REQ-011 err  output  1  sticky protocol/line error flag.

Function
REQ-012 Frame format SHALL be 1 start bit, 8 data bits LSB first, even parity, 2 stop bits.
REQ-013 The state machine SHALL have exactly these states: IDLE, INSTR, STCS_DATA, GUARD, RESP_TX.
REQ-014 IDLE: a received byte 8'h55 (SYNC) SHALL move to INSTR; any other byte SHALL be discarded without setting err.
REQ-015 INSTR, byte {4'h8,a}: LDCS SHALL move to GUARD with register a latched.
REQ-016 INSTR, byte {4'hC,a}: STCS SHALL move to STCS_DATA with address a latched.
REQ-017 INSTR, any other byte: err SHALL be set and the state SHALL return to IDLE.
REQ-018 STCS_DATA: the received byte d SHALL be written to register a, cs_we SHALL pulse for 1 cycle with cs_waddr=a and cs_wdata=d, and the state SHALL return to IDLE; no response is sent.
REQ-019 Writes to register 0x0 SHALL pulse cs_we but SHALL leave the register unchanged.
REQ-020 GUARD SHALL count GUARD_CYCLES clk cycles with tx=1, then move to RESP_TX.
REQ-021 RESP_TX SHALL transmit the latched register value, and SHALL return to IDLE on the cycle the transmitter reports ready.
REQ-022 rx SHALL be ignored during GUARD and RESP_TX, because the line is half-duplex and the echo is discarded.
REQ-023 A parity or framing error in IDLE, INSTR or STCS_DATA SHALL set err, abort the instruction and return to IDLE.
REQ-024 A SYNC is required before every instruction; the byte following a completed instruction is treated as a possible SYNC.
REQ-025 err SHALL be cleared only by reset, or as defined in REQ-030.
REQ-026 Registers 0x1..0xF SHALL be 8 bits wide; address decode SHALL use all 4 bits and there is no wrap.

Reset
REQ-027 While rst=0 at a clk edge: state IDLE, tx=1, busy=0, err=0, cs_we=0, cs_waddr=0, cs_wdata=0, registers 0x1..0xF =0.
REQ-028 Reset asserted mid-frame or mid-response SHALL abort immediately, with tx high on the next cycle.
REQ-029 The internal uart SHALL be driven with active-high reset ~rst.

Configuration
REQ-030 With UPDI_RESPONDER_ERR_REG_EN defined: register 0x2 bit0 SHALL read err, bits 7:1 SHALL read 0, and an STCS to 0x2 with d[0]=1 SHALL clear err; register 0x2 is otherwise not storable.
REQ-031 Without UPDI_RESPONDER_ERR_REG_EN: register 0x2 SHALL be an ordinary storage register.

Structure
REQ-032 Shared package updi_pkg SHALL hold: SYNC_BYTE=8'h55, opcode nibbles OP_LDCS=4'h8 and OP_STCS=4'hC, and the responder state enum typedef.
REQ-033 The sub-module SHALL be one instance of the existing uart with DATA_BITS=8, PARITY_BIT="even", STOP_BITS=2; the FSM and register file stay in updi_responder.

Verification
REQ-034 Stimulus: 55, C3, A7. Required: one cs_we pulse with waddr=3, wdata=A7, no tx activity, busy=0 after the pulse.
REQ-035 Stimulus: 55, C3, A7, 55, 83. Required: after 2 idle cycles tx carries frame 0, A7, parity 1, stop 1 1.
REQ-036 Stimulus: 55, 80. Required: response byte 30; a prior STCS of FF to 0x0 does not alter it.
REQ-037 Stimulus: 55, 12. Required: err=1, state IDLE; a following 55, 81 returns 00.
REQ-038 Stimulus: 55 with corrupted parity. Required: err=1; a following 83 without SYNC produces no response.
REQ-039 Stimulus: rst=0 mid-response. Required: tx=1 next cycle, busy=0; if UPDI_RESPONDER_ERR_REG_EN is defined, STCS 0x2 with 01 clears err.
